// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronizes and debounces the A/B phases, then
// turns each legal Gray-code transition into a step event and a wrapping position count.
module quad_step_decoder #(
   parameter int WIDTH      = 4,
   parameter int FILTER_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clr,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step_pulse,
   output logic             err
);

   localparam int SW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(FILTER_LEN);

   typedef enum logic {
      ST_INIT,
      ST_TRACK
   } state_t;

   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       cand_q, cand_d;
   logic [SW-1:0]    stab_q, stab_d;
   logic [1:0]       filt_q, filt_d;
   logic             accept_q, accept_d;
   state_t           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic             move_up, move_down, move_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {enc_a, enc_b};
         sync2_q <= sync1_q;
      end
   end

   // Acceptance fires once when a run of identical samples first reaches FILTER_LEN,
   // including the very first run after reset so INIT always gets a value to adopt.
   always_comb begin
      cand_d   = cand_q;
      stab_d   = stab_q;
      filt_d   = filt_q;
      accept_d = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         stab_d = SW'(1);
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + SW'(1);
      end
      if ((stab_d == STAB_MAX) && ((stab_q != STAB_MAX) || (sync2_q != cand_q))) begin
         accept_d = 1'b1;
         filt_d   = cand_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q   <= 2'b00;
         stab_q   <= '0;
         filt_q   <= 2'b00;
         accept_q <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         stab_q   <= stab_d;
         filt_q   <= filt_d;
         accept_q <= accept_d;
      end
   end

   always_comb begin
      move_up      = 1'b0;
      move_down    = 1'b0;
      move_illegal = 1'b0;
      case ({prev_q, filt_q})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: move_up      = 1'b1;
         4'b0100, 4'b1101, 4'b1011, 4'b0010: move_down    = 1'b1;
         4'b0011, 4'b1100, 4'b0110, 4'b1001: move_illegal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      count_d = count_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (accept_q) begin
         prev_d = filt_q;
         if (state_q == ST_INIT) begin
            state_d = ST_TRACK;
         end else if (move_up) begin
            count_d = count_q + WIDTH'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
         end else if (move_down) begin
            count_d = count_q - WIDTH'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
         end else if (move_illegal) begin
            err_d = 1'b1;
         end
      end
      // Clear overrides the count and swallows the pulse, but direction still tracks.
      if (clr) begin
         count_d = '0;
         step_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         prev_q  <= 2'b00;
         count_q <= '0;
         dir_q   <= 1'b1;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   assign count      = count_q;
   assign dir        = dir_q;
   assign step_pulse = step_q;
   assign err        = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboarded bench for quad_step_decoder: a run-length / Gray-position reference
// model predicts step events; a negedge monitor checks them against the DUT.
module tb_quad_step_decoder;

   localparam int WIDTH      = 4;
   localparam int FILTER_LEN = 3;
   localparam int LAT        = 6;
   localparam int MODV       = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enc_a = 1'b0;
   logic             enc_b = 1'b0;
   logic             clr = 1'b0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             step_pulse;
   logic             err;

   always #5 clk = ~clk;

   quad_step_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FILTER_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .clr        (clr),
      .err_clr    (err_clr),
      .count      (count),
      .dir        (dir),
      .step_pulse (step_pulse),
      .err        (err)
   );

   typedef struct {
      int cnt;
      int d;
      int at;
   } ev_t;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   pulses = 0;
   int   last_pulse_cyc = -1;
   ev_t  exp_q[$];

   // reference model state
   logic [1:0] pipe[$];
   logic [1:0] run_val;
   int         run_len;
   bit         pend;
   logic [1:0] pend_val;
   bit         has_prev;
   logic [1:0] prev;
   int         m_count;
   int         m_dir;
   int         m_err;

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int gpos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gcode(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_reset();
      pipe.delete();
      pipe.push_back(2'b00);
      pipe.push_back(2'b00);
      run_val  = 2'b00;
      run_len  = 0;
      pend     = 1'b0;
      has_prev = 1'b0;
      prev     = 2'b00;
      m_count  = 0;
      m_dir    = 1;
      m_err    = 0;
      exp_q.delete();
   endtask

   // Reference model: a position is accepted once it has been seen FILTER_LEN edges
   // in a row (two edges late), and its effect lands on the following edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            model_reset();
         end else begin
            bit stepped;
            bit illegal;
            logic [1:0] v;
            stepped = 1'b0;
            illegal = 1'b0;
            if (pend) begin
               pend = 1'b0;
               if (!has_prev) begin
                  has_prev = 1'b1;
               end else begin
                  int d;
                  d = (gpos(pend_val) - gpos(prev) + 4) % 4;
                  if (d == 1) begin
                     m_count = (m_count + 1) % MODV;
                     m_dir   = 1;
                     stepped = 1'b1;
                  end else if (d == 3) begin
                     m_count = (m_count + MODV - 1) % MODV;
                     m_dir   = 0;
                     stepped = 1'b1;
                  end else if (d == 2) begin
                     illegal = 1'b1;
                  end
               end
               prev = pend_val;
            end
            if (err_clr) m_err = 0;
            if (illegal) m_err = 1;
            if (clr) m_count = 0;
            if (stepped && !clr) exp_q.push_back('{m_count, m_dir, cyc});
            v = pipe.pop_front();
            pipe.push_back({enc_a, enc_b});
            if (v == run_val) begin
               run_len++;
            end else begin
               run_val = v;
               run_len = 1;
            end
            if (run_len == FILTER_LEN) begin
               pend     = 1'b1;
               pend_val = run_val;
            end
         end
      end
   end

   // Monitor: pops an expected event on every step_pulse, and tracks steady state.
   initial begin
      bit last_step;
      last_step = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (step_pulse) begin
               pulses++;
               last_pulse_cyc = cyc;
               check("pulse_gap", int'(last_step), 0);
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", 1, 0);
               end else begin
                  ev_t e;
                  e = exp_q.pop_front();
                  check("pulse_count", int'(count), e.cnt);
                  check("pulse_dir", int'(dir), e.d);
                  check("pulse_cycle", cyc, e.at);
               end
            end
            check("count", int'(count), m_count);
            check("dir", int'(dir), m_dir);
            check("err", int'(err), m_err);
            last_step = step_pulse;
         end else begin
            last_step = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [1:0] v, input int n);
      {enc_a, enc_b} = v;
      tick(n);
   endtask

   task automatic do_reset(input logic [1:0] v);
      rst_n = 1'b0;
      clr = 1'b0;
      err_clr = 1'b0;
      {enc_a, enc_b} = v;
      tick(3);
      rst_n = 1'b1;
   endtask

   initial begin
      int p0;
      int d0;
      int cur;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int d0;
      int cur;
      tick(1);

      // reset while resting at 11: adopted silently
      do_reset(2'b11);
      tick(10);
      check("t1_count", int'(count), 0);
      check("t1_err", int'(err), 0);
      check("t1_dir", int'(dir), 1);
      check("t1_pulses", pulses, 0);
      $display("t1 reset at 11: count=%0d dir=%0d err=%0d", count, dir, err);

      // four up steps from 00 with latency check
      do_reset(2'b00);
      tick(10);
      p0 = pulses;
      d0 = cyc;
      hold(2'b01, 10);
      check("t2_latency", last_pulse_cyc - d0, LAT);
      hold(2'b11, 10);
      hold(2'b10, 10);
      hold(2'b00, 10);
      check("t2_count", int'(count), 4);
      check("t2_dir", int'(dir), 1);
      check("t2_pulses", pulses - p0, 4);
      $display("t2 up sequence: count=%0d dir=%0d", count, dir);

      // wrap below zero and back up through zero
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(2);
      check("t3_clr", int'(count), 0);
      hold(2'b10, 10);
      check("t3_wrap_down", int'(count), MODV - 1);
      check("t3_dir_down", int'(dir), 0);
      hold(2'b00, 10);
      hold(2'b01, 10);
      hold(2'b11, 10);
      hold(2'b10, 10);
      check("t3_wrap_up", int'(count), 3);
      check("t3_dir_up", int'(dir), 1);
      hold(2'b00, 10);
      $display("t3 wrap: count=%0d dir=%0d", count, dir);

      // glitch rejection and minimum accepted pulse
      p0 = pulses;
      hold(2'b10, 2);
      hold(2'b00, 10);
      check("t4_glitch_pulses", pulses - p0, 0);
      check("t4_glitch_count", int'(count), 4);
      check("t4_glitch_err", int'(err), 0);
      hold(2'b10, 3);
      hold(2'b00, 10);
      check("t4_min_pulses", pulses - p0, 2);
      check("t4_min_count", int'(count), 4);
      $display("t4 glitch: count=%0d pulses=%0d", count, pulses - p0);

      // illegal jumps and err_clr priority
      hold(2'b11, 10);
      check("t5_err_set", int'(err), 1);
      check("t5_count", int'(count), 4);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(2);
      check("t5_err_clr", int'(err), 0);
      {enc_a, enc_b} = 2'b00;
      tick(LAT - 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(3);
      check("t5_set_wins", int'(err), 1);
      $display("t5 illegal: err=%0d count=%0d", err, count);

      // clr coincident with a decoded up step from 7
      hold(2'b01, 10);
      hold(2'b11, 10);
      hold(2'b10, 10);
      check("t6_count7", int'(count), 7);
      p0 = pulses;
      {enc_a, enc_b} = 2'b00;
      tick(LAT - 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("t6_clr_count", int'(count), 0);
      check("t6_clr_step", int'(step_pulse), 0);
      check("t6_clr_dir", int'(dir), 1);
      tick(5);
      check("t6_clr_pulses", pulses - p0, 0);
      hold(2'b01, 10);
      check("t6_next", int'(count), 1);
      $display("t6 clr vs step: count=%0d", count);

      // randomized walk with glitches, illegal jumps, clr and err_clr
      cur = 1;
      for (int i = 0; i < 400; i++) begin
         int r;
         int n;
         int nxt;
         r = int'($urandom_range(0, 99));
         n = int'($urandom_range(1, 8));
         if (r < 70) nxt = ($urandom_range(0, 1) != 0) ? cur + 1 : cur + 3;
         else if (r < 80) nxt = cur + 2;
         else nxt = cur;
         nxt = nxt & 3;
         if (r >= 80 && r < 90) begin
            hold(gcode(cur + 1), int'($urandom_range(1, 2)));
         end
         {enc_a, enc_b} = gcode(nxt);
         clr = ($urandom_range(0, 15) == 0);
         err_clr = ($urandom_range(0, 7) == 0);
         tick(1);
         clr = 1'b0;
         err_clr = 1'b0;
         if (n > 1) tick(n - 1);
         cur = nxt;
      end
      hold(gcode(cur), 12);
      $display("random walk done: count=%0d dir=%0d err=%0d", count, dir, err);

      // reset in the middle of a filter window; new position adopted silently
      {enc_a, enc_b} = gcode(cur + 1);
      tick(3);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      p0 = pulses;
      tick(12);
      check("t7_count", int'(count), 0);
      check("t7_dir", int'(dir), 1);
      check("t7_err", int'(err), 0);
      check("t7_pulses", pulses - p0, 0);
      $display("t7 mid reset: count=%0d dir=%0d err=%0d", count, dir, err);

      tick(5);
      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
